// File: rtl/dsa_cmd_pkg.sv
// ============================================================================
//  Module   : dsa_cmd_pkg
//  Brief    : Shared types, field geometry and error-bit indices for the
//             DSA command bridge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsa_cmd_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int CMD_TYPE_W = 4;
    localparam int HDR_W      = REG_ADDR_W + CMD_TYPE_W;
    localparam int ERR_W      = 4;

    localparam int ERR_BAD_CMD   = 0;
    localparam int ERR_DROPPED   = 1;
    localparam int ERR_TIMEOUT   = 2;
    localparam int ERR_ADDR_WRAP = 3;

    typedef enum logic [CMD_TYPE_W-1:0] {
        CMD_NOP       = 4'd0,
        CMD_WRITE_REG = 4'd1,
        CMD_READ_REG  = 4'd2,
        CMD_WRITE_MEM = 4'd3,
        CMD_READ_MEM  = 4'd4,
        CMD_SET_ADDR  = 4'd5,
        CMD_CLR_ERR   = 4'd6
    } cmd_type_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RD_REG  = 2'd1;
    localparam state_t ST_MEM_REQ = 2'd2;
    localparam state_t ST_MEM_RD  = 2'd3;

    function automatic logic is_mem_cmd(input logic [CMD_TYPE_W-1:0] t);
        return (t == CMD_WRITE_MEM) || (t == CMD_READ_MEM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dsa_cmd_addr_ptr.sv
// ============================================================================
//  Module   : dsa_cmd_addr_ptr
//  Brief    : Memory address pointer with payload shift-load, post-handshake
//             increment and wrap at MEM_DEPTH-1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsa_cmd_addr_ptr #(
    parameter int ADDR_W    = 18,
    parameter int PAY_W     = 8,
    parameter int MEM_DEPTH = 262144
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [PAY_W-1:0]  i_load_data,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_ptr,
    output logic              o_wrap
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(MEM_DEPTH - 1);

    logic [ADDR_W-1:0] r_ptr;
    logic              w_at_last;

    assign w_at_last = (r_ptr == c_last);
    assign o_wrap    = i_inc && w_at_last;
    assign o_ptr     = r_ptr;

    // Load and increment come from disjoint FSM states, so never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= {r_ptr[ADDR_W-PAY_W-1:0], i_load_data};
        end else if (i_inc) begin
            r_ptr <= w_at_last ? '0 : r_ptr + ADDR_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dsa_cmd_bridge.sv
// ============================================================================
//  Module   : dsa_cmd_bridge
//  Brief    : VJTAG command-word decoder driving DSA registers, a memory
//             port with timeout, control pulses and sticky error flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsa_cmd_bridge
    import dsa_cmd_pkg::*;
#(
    parameter int   CMD_W     = 16,
    parameter int   ADDR_W    = 18,
    parameter int   MEM_DEPTH = 262144,
    parameter int   TIMEOUT   = 1023,
    localparam int  PAY_W     = CMD_W - HDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic [CMD_W-1:0]      cmd_word,
    output logic                  cmd_ready,
    output logic                  reg_wr_en,
    output logic [REG_ADDR_W-1:0] reg_addr,
    output logic [PAY_W-1:0]      reg_wdata,
    input  logic [PAY_W-1:0]      reg_rdata,
    output logic                  start_pulse,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [PAY_W-1:0]      mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [PAY_W-1:0]      mem_rdata,
    output logic                  resp_valid,
    output logic [PAY_W-1:0]      resp_data,
    output logic [ERR_W-1:0]      err_flags
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [TMR_W-1:0]      r_timer;
    logic [ERR_W-1:0]      r_err;
    logic [ERR_W-1:0]      w_err_set;
    logic                  r_reg_wr_en;
    logic [REG_ADDR_W-1:0] r_reg_addr;
    logic [PAY_W-1:0]      r_reg_wdata;
    logic                  r_start;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [PAY_W-1:0]      r_mem_wdata;
    logic                  r_resp_valid;
    logic [PAY_W-1:0]      r_resp_data;

    logic [REG_ADDR_W-1:0] w_reg_field;
    logic [CMD_TYPE_W-1:0] w_type;
    logic [PAY_W-1:0]      w_payload;
    logic                  w_accept;
    logic                  w_do_wreg;
    logic                  w_do_rreg;
    logic                  w_do_mem;
    logic                  w_do_setaddr;
    logic                  w_do_clr;
    logic                  w_bad;
    logic                  w_handshake;
    logic                  w_waiting;
    logic                  w_timeout;
    logic                  w_rd_capture;
    logic [ADDR_W-1:0]     w_ptr;
    logic                  w_wrap;

    assign w_reg_field = cmd_word[CMD_W-1 -: REG_ADDR_W];
    assign w_type      = cmd_word[CMD_W-REG_ADDR_W-1 -: CMD_TYPE_W];
    assign w_payload   = cmd_word[PAY_W-1:0];
    assign w_accept    = cmd_valid && (r_state == ST_IDLE);

    dsa_cmd_addr_ptr #(
        .ADDR_W    (ADDR_W),
        .PAY_W     (PAY_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_addr_ptr (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_do_setaddr),
        .i_load_data (w_payload),
        .i_inc       (w_handshake),
        .o_ptr       (w_ptr),
        .o_wrap      (w_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_do_rreg) begin
                    w_state_next = ST_RD_REG;
                end else if (w_do_mem) begin
                    w_state_next = ST_MEM_REQ;
                end
            end
            ST_RD_REG: w_state_next = ST_IDLE;
            ST_MEM_REQ: begin
                if (mem_ready) begin
                    w_state_next = (r_mem_we || mem_rvalid) ? ST_IDLE : ST_MEM_RD;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MEM_RD: begin
                if (mem_rvalid || w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_do_wreg    = 1'b0;
        w_do_rreg    = 1'b0;
        w_do_mem     = 1'b0;
        w_do_setaddr = 1'b0;
        w_do_clr     = 1'b0;
        w_bad        = 1'b0;
        if (w_accept) begin
            case (w_type)
                CMD_NOP:       begin end
                CMD_WRITE_REG: w_do_wreg    = 1'b1;
                CMD_READ_REG:  w_do_rreg    = 1'b1;
                CMD_WRITE_MEM,
                CMD_READ_MEM:  w_do_mem     = is_mem_cmd(w_type);
                CMD_SET_ADDR:  w_do_setaddr = 1'b1;
                CMD_CLR_ERR:   w_do_clr     = 1'b1;
                default:       w_bad        = 1'b1;
            endcase
        end
        w_handshake  = (r_state == ST_MEM_REQ) && mem_ready;
        w_waiting    = ((r_state == ST_MEM_REQ) && !mem_ready) ||
                       ((r_state == ST_MEM_RD)  && !mem_rvalid);
        w_timeout    = w_waiting && (r_timer == c_tmr_last);
        w_rd_capture = (w_handshake && !r_mem_we && mem_rvalid) ||
                       ((r_state == ST_MEM_RD) && mem_rvalid);
        w_err_set                = '0;
        w_err_set[ERR_BAD_CMD]   = w_bad;
        w_err_set[ERR_DROPPED]   = cmd_valid && (r_state != ST_IDLE);
        w_err_set[ERR_TIMEOUT]   = w_timeout;
        w_err_set[ERR_ADDR_WRAP] = w_wrap;
    end

    // Any state change restarts the wait count, covering MEM_REQ -> MEM_RD.
    always_ff @(posedge clk) begin
        if (rst || (w_state_next != r_state)) begin
            r_timer <= '0;
        end else if (w_waiting) begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_wr_en  <= 1'b0;
            r_reg_addr   <= '0;
            r_reg_wdata  <= '0;
            r_start      <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_err        <= '0;
        end else begin
            r_reg_wr_en  <= w_do_wreg;
            r_start      <= w_do_wreg && (w_reg_field == '0) && w_payload[0];
            r_resp_valid <= 1'b0;
            if (w_do_wreg || w_do_rreg) begin
                r_reg_addr <= w_reg_field;
            end
            if (w_do_wreg) begin
                r_reg_wdata <= w_payload;
            end
            if (w_do_mem) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= (w_type == CMD_WRITE_MEM);
                r_mem_addr <= w_ptr;
                if (w_type == CMD_WRITE_MEM) begin
                    r_mem_wdata <= w_payload;
                end
            end else if (w_handshake || ((r_state == ST_MEM_REQ) && w_timeout)) begin
                r_mem_req <= 1'b0;
            end
            if (r_state == ST_RD_REG) begin
                r_resp_data  <= reg_rdata;
                r_resp_valid <= 1'b1;
            end else if (w_rd_capture) begin
                r_resp_data  <= mem_rdata;
                r_resp_valid <= 1'b1;
            end else if (w_timeout && !r_mem_we) begin
                r_resp_data  <= '1;
                r_resp_valid <= 1'b1;
            end
            // Clearing takes priority over any flag raised in the same cycle.
            if (w_do_clr) begin
                r_err <= '0;
            end else begin
                r_err <= r_err | w_err_set;
            end
        end
    end

    assign cmd_ready   = (r_state == ST_IDLE);
    assign reg_wr_en   = r_reg_wr_en;
    assign reg_addr    = r_reg_addr;
    assign reg_wdata   = r_reg_wdata;
    assign start_pulse = r_start;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign err_flags   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dsa_cmd_bridge.sv
// ============================================================================
//  Module   : tb_dsa_cmd_bridge
//  Brief    : Self-checking bench for dsa_cmd_bridge: register vector table,
//             directed memory/timeout/reset sequences and a randomized run
//             against a pointer/memory/error-flag model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsa_cmd_bridge;

    localparam int MEM_DEPTH = 262144;
    localparam int TIMEOUT   = 1023;

    localparam logic [3:0] T_NOP  = 4'd0;
    localparam logic [3:0] T_WREG = 4'd1;
    localparam logic [3:0] T_RREG = 4'd2;
    localparam logic [3:0] T_WMEM = 4'd3;
    localparam logic [3:0] T_RMEM = 4'd4;
    localparam logic [3:0] T_SETA = 4'd5;
    localparam logic [3:0] T_CLR  = 4'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [15:0] cmd_word;
    logic        cmd_ready;
    logic        reg_wr_en;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        start_pulse;
    logic        mem_req;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [3:0]  err_flags;

    int n_checks = 0;
    int n_errors = 0;

    int         m_ptr;
    logic [3:0] m_err;
    logic [7:0] mmem [int];
    logic [7:0] dmem [int];

    always #5 clk = ~clk;

    dsa_cmd_bridge #(
        .CMD_W     (16),
        .ADDR_W    (18),
        .MEM_DEPTH (MEM_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_word    (cmd_word),
        .cmd_ready   (cmd_ready),
        .reg_wr_en   (reg_wr_en),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .start_pulse (start_pulse),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .err_flags   (err_flags)
    );

    typedef struct {
        logic [3:0] addr;
        logic [3:0] typ;
        logic [7:0] pay;
        logic [7:0] rdata;
        logic       exp_wr;
        logic       exp_start;
        logic [3:0] exp_raddr;
        logic       exp_rv;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t tbl [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] t, input logic [7:0] p);
        chk("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_word  = {a, t, p};
        tick();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [7:0] init_val(input int a);
        return 8'(a * 7 + 3);
    endfunction

    task automatic model_advance();
        if (m_ptr == MEM_DEPTH - 1) begin
            m_ptr    = 0;
            m_err[3] = 1'b1;
        end else begin
            m_ptr++;
        end
    endtask

    // Called one cycle after a memory command was accepted.
    task automatic mem_op(input logic we, input logic [7:0] pay, input int exp_addr,
                          input int lat, input int rv_lat,
                          input logic [7:0] rd, input logic [7:0] exp_rd);
        chk("mem_req_set", {31'd0, mem_req}, 32'd1);
        chk("mem_addr", {14'd0, mem_addr}, exp_addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, we});
        if (we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, pay});
        repeat (lat) begin
            tick();
            chk("mem_req_held", {31'd0, mem_req}, 32'd1);
        end
        mem_ready = 1'b1;
        if (!we && rv_lat == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
        end
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
        if (!we) begin
            if (rv_lat > 0) begin
                chk("mem_rd_wait", {31'd0, resp_valid}, 32'd0);
                repeat (rv_lat - 1) tick();
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
                tick();
                mem_rvalid = 1'b0;
            end
            chk("mem_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("mem_resp_data", {24'd0, resp_data}, {24'd0, exp_rd});
        end
        chk("mem_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         r;
        int         n;
        int         lat;
        int         rvl;
        logic [3:0] a;
        logic [7:0] p;
        logic [7:0] rd;
        logic [7:0] ex;

        tbl[0] = '{4'h1, T_WREG, 8'h20, 8'h00, 1'b1, 1'b0, 4'h1, 1'b0, 8'h00};
        tbl[1] = '{4'h0, T_WREG, 8'h03, 8'h00, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00};
        tbl[2] = '{4'h0, T_WREG, 8'h02, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00};
        tbl[3] = '{4'h6, T_RREG, 8'h00, 8'h02, 1'b0, 1'b0, 4'h6, 1'b1, 8'h02};
        tbl[4] = '{4'hF, T_RREG, 8'h00, 8'hA5, 1'b0, 1'b0, 4'hF, 1'b1, 8'hA5};
        tbl[5] = '{4'h3, T_NOP,  8'h55, 8'h00, 1'b0, 1'b0, 4'hF, 1'b0, 8'h00};
        tbl[6] = '{4'h2, T_WREG, 8'h01, 8'h00, 1'b1, 1'b0, 4'h2, 1'b0, 8'h00};

        rst = 1'b1; cmd_valid = 1'b0; cmd_word = '0; reg_rdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        chk("rst_reg_wr_en", {31'd0, reg_wr_en}, 32'd0);
        chk("rst_start", {31'd0, start_pulse}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", {14'd0, mem_addr}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", {24'd0, resp_data}, 32'd0);
        chk("rst_err", {28'd0, err_flags}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            reg_rdata = tbl[i].rdata;
            send(tbl[i].addr, tbl[i].typ, tbl[i].pay);
            chk("tbl_wr_en", {31'd0, reg_wr_en}, {31'd0, tbl[i].exp_wr});
            chk("tbl_start", {31'd0, start_pulse}, {31'd0, tbl[i].exp_start});
            chk("tbl_reg_addr", {28'd0, reg_addr}, {28'd0, tbl[i].exp_raddr});
            if (tbl[i].exp_wr) chk("tbl_wdata", {24'd0, reg_wdata}, {24'd0, tbl[i].pay});
            tick();
            chk("tbl_wr_en_off", {31'd0, reg_wr_en}, 32'd0);
            chk("tbl_start_off", {31'd0, start_pulse}, 32'd0);
            chk("tbl_resp_valid", {31'd0, resp_valid}, {31'd0, tbl[i].exp_rv});
            if (tbl[i].exp_rv) chk("tbl_resp_data", {24'd0, resp_data}, {24'd0, tbl[i].exp_rdata});
        end

        // Burst of writes from a shifted-in base address.
        send(4'h0, T_SETA, 8'h01);
        send(4'h0, T_SETA, 8'h00);
        for (int i = 0; i < 5; i++) begin
            send(4'h0, T_WMEM, 8'(8'h10 + i));
            mem_op(1'b1, 8'(8'h10 + i), 32'h100 + i, 2, 0, 8'h00, 8'h00);
        end

        // Wrap at the last address with same-cycle ready and rvalid.
        send(4'h0, T_CLR, 8'h00);
        send(4'h0, T_SETA, 8'h03);
        send(4'h0, T_SETA, 8'hFF);
        send(4'h0, T_SETA, 8'hFF);
        send(4'h0, T_RMEM, 8'h00);
        mem_op(1'b0, 8'h00, 32'h3FFFF, 0, 0, 8'h3C, 8'h3C);
        chk("wrap_err", {28'd0, err_flags}, 32'h8);
        send(4'h0, T_WMEM, 8'h77);
        mem_op(1'b1, 8'h77, 32'h0, 1, 0, 8'h00, 8'h00);

        // Read timeout with a command dropped while busy.
        send(4'h0, T_CLR, 8'h00);
        send(4'h0, T_SETA, 8'h42);
        send(4'h0, T_RMEM, 8'h00);
        chk("to_mem_addr", {14'd0, mem_addr}, 32'h142);
        n = 0;
        while (mem_req && n < TIMEOUT + 10) begin
            cmd_valid = (n == 3);
            cmd_word  = 16'h0000;
            n++;
            tick();
        end
        cmd_valid = 1'b0;
        chk("to_cycles", n, TIMEOUT);
        chk("to_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("to_resp_data", {24'd0, resp_data}, 32'hFF);
        chk("to_err", {28'd0, err_flags}, 32'h6);
        chk("to_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        send(4'h0, T_WMEM, 8'h11);
        mem_op(1'b1, 8'h11, 32'h142, 0, 0, 8'h00, 8'h00);
        send(4'h0, 4'd9, 8'h00);
        chk("bad_cmd_err", {28'd0, err_flags}, 32'h7);
        send(4'h0, T_CLR, 8'h00);
        chk("clr_err", {28'd0, err_flags}, 32'h0);

        // Reset while a write request is outstanding.
        send(4'h0, T_WMEM, 8'h99);
        chk("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_rst_mem_req", {31'd0, mem_req}, 32'd0);

        // Randomized run against the reference model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        m_err = 4'h0;
        mmem.delete();
        dmem.delete();
        for (int k = 0; k < 250; k++) begin
            r   = $urandom_range(0, 19);
            a   = 4'($urandom_range(0, 15));
            p   = 8'($urandom_range(0, 255));
            lat = $urandom_range(0, 3);
            rvl = $urandom_range(0, 3);
            case (r)
                0: send(a, T_NOP, p);
                1, 2, 3: begin
                    send(a, T_WREG, p);
                    chk("rnd_wr_en", {31'd0, reg_wr_en}, 32'd1);
                    chk("rnd_reg_addr", {28'd0, reg_addr}, {28'd0, a});
                    chk("rnd_reg_wdata", {24'd0, reg_wdata}, {24'd0, p});
                    chk("rnd_start", {31'd0, start_pulse}, {31'd0, (a == 4'h0) && p[0]});
                end
                4, 5, 6: begin
                    reg_rdata = p ^ {a, a};
                    send(a, T_RREG, 8'h00);
                    tick();
                    chk("rnd_rreg_valid", {31'd0, resp_valid}, 32'd1);
                    chk("rnd_rreg_data", {24'd0, resp_data}, {24'd0, p ^ {a, a}});
                end
                7, 8, 9, 10: begin
                    send(a, T_WMEM, p);
                    dmem[int'(mem_addr)] = mem_wdata;
                    mmem[m_ptr] = p;
                    mem_op(1'b1, p, m_ptr, lat, 0, 8'h00, 8'h00);
                    model_advance();
                end
                11, 12, 13, 14: begin
                    send(a, T_RMEM, p);
                    rd = dmem.exists(int'(mem_addr)) ? dmem[int'(mem_addr)] : init_val(int'(mem_addr));
                    ex = mmem.exists(m_ptr) ? mmem[m_ptr] : init_val(m_ptr);
                    mem_op(1'b0, 8'h00, m_ptr, lat, rvl, rd, ex);
                    model_advance();
                end
                15, 16: begin
                    send(a, T_SETA, p);
                    m_ptr = ((m_ptr * 256) + int'(p)) % (1 << 18);
                end
                17: begin
                    send(a, T_CLR, p);
                    m_err = 4'h0;
                end
                default: begin
                    send(a, 4'($urandom_range(7, 15)), p);
                    m_err[0] = 1'b1;
                end
            endcase
            chk("rnd_err_flags", {28'd0, err_flags}, {28'd0, m_err});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
